cipher_arbiter: RTL

Shares one N-bit XOR key stage between two plaintext/ciphertext streams (channel A, channel B). Round-robin arbitration with a bounded burst length, valid/ready handshakes on both inputs and on the single registered output, and a loadable key register. Sits between the two stream sources and the downstream byte sink of the XOR cipher. The existing 2:1 `mux` selects the granted channel's data.

---
 rtl/cipher_arb_pkg.sv | 21 ++
 rtl/mux.sv | 13 +
 rtl/cipher_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cipher_arb_pkg.sv
// Shared types and constants for the two-channel XOR cipher arbiter.
// Optional feature macro: CIPHER_ARB_KEY_ROTATE_EN (see cipher_arbiter.sv).
package cipher_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_e;

    // Channel indices, also the encoding of out_src and last_grant
    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    // Grant state that serves the given channel
    function automatic arb_state_e grant_state(input logic ch);
        return (ch == CH_B) ? GRANT_B : GRANT_A;
    endfunction

endpackage

// File: rtl/mux.sv
// Generic 2:1 data multiplexer: y = sel ? a : b.
module mux #(
    parameter int unsigned N = 8
) (
    input  logic         sel,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    assign y = sel ? a : b;

endmodule

// File: rtl/cipher_arbiter.sv
// Two-stream round-robin arbiter sharing one XOR key stage, with bounded
// bursts, valid/ready handshakes and a single registered output beat.
// Optional feature: define CIPHER_ARB_KEY_ROTATE_EN to rotate the key left
// by one bit after every accepted beat (a same-cycle key_load wins).
module cipher_arbiter
    import cipher_arb_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [N-1:0] key_in,
    input  logic         a_valid,
    input  logic [N-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [N-1:0] b_data,
    output logic         b_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         out_src,
    input  logic         out_ready
);

    localparam int unsigned CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_grant_q, last_grant_d;
    logic [N-1:0]  key_q, key_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic          out_src_q, out_src_d;

    logic          pipe_ready;
    logic          a_acc, b_acc, acc;
    logic [N-1:0]  sel_data;

    logic          own_ch, other_ch;
    logic          own_valid, other_valid;

    // Handshake decode: a new beat may enter when the output slot frees up
    assign pipe_ready = !out_valid_q || out_ready;
    assign a_ready    = (state_q == GRANT_A) && pipe_ready;
    assign b_ready    = (state_q == GRANT_B) && pipe_ready;
    assign a_acc      = a_valid && a_ready;
    assign b_acc      = b_valid && b_ready;
    assign acc        = a_acc || b_acc;

    // Granted channel's data feeds the XOR stage
    mux #(.N(N)) u_mux (
        .sel (state_q == GRANT_A),
        .a   (a_data),
        .b   (b_data),
        .y   (sel_data)
    );

    // Next-state logic: round-robin grant, burst counting and release
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        own_ch       = (state_q == GRANT_B) ? CH_B : CH_A;
        other_ch     = ~own_ch;
        own_valid    = (own_ch == CH_B) ? b_valid : a_valid;
        other_valid  = (own_ch == CH_B) ? a_valid : b_valid;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (a_valid && b_valid) begin
                    state_d      = grant_state(~last_grant_q);
                    last_grant_d = ~last_grant_q;
                end else if (a_valid) begin
                    state_d      = GRANT_A;
                    last_grant_d = CH_A;
                end else if (b_valid) begin
                    state_d      = GRANT_B;
                    last_grant_d = CH_B;
                end
            end

            GRANT_A, GRANT_B: begin
                if (acc) begin
                    if (cnt_q == CNT_LAST) begin
                        // Burst exhausted: the other side gets priority
                        cnt_d = '0;
                        if (other_valid) begin
                            state_d      = grant_state(other_ch);
                            last_grant_d = other_ch;
                        end else if (own_valid) begin
                            state_d      = grant_state(own_ch);
                            last_grant_d = own_ch;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (!own_valid) begin
                    // Granted source went quiet: hand over or fall idle
                    cnt_d = '0;
                    if (other_valid) begin
                        state_d      = grant_state(other_ch);
                        last_grant_d = other_ch;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Key register update; an accepted beat always sees the pre-update key
    always_comb begin
        key_d = key_q;
`ifdef CIPHER_ARB_KEY_ROTATE_EN
        if (acc) begin
            key_d = {key_q[N-2:0], key_q[N-1]};
        end
`endif
        if (key_load) begin
            key_d = key_in;
        end
    end

    // Output register: capture encrypted beat, drain when the sink takes it
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (acc) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data ^ key_q;
            out_src_d   = b_acc ? CH_B : CH_A;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= CH_B;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Datapath registers: key and output beat
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= CH_A;
        end else begin
            key_q       <= key_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifndef SYNTHESIS
    // Sources must hold data steady while a beat is offered but not taken
    a_data_stable: assert property (@(posedge clk) disable iff (rst)
        (a_valid && !a_ready) |=> (!a_valid || $stable(a_data)));
    b_data_stable: assert property (@(posedge clk) disable iff (rst)
        (b_valid && !b_ready) |=> (!b_valid || $stable(b_data)));
`endif

endmodule
